// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the pipeline hazard control unit
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic stall_mux_sel;
        logic pipe_hold;
        logic if_flush;
        logic id_flush;
        logic ex_flush;
    } hz_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use stall, branch flush and memory freeze control for the 5-stage core
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int LOAD_STALLS = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic              ex_mem_branch,
    input  logic              ex_mem_zero,
    input  logic              ex_mem_jump,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              clr_counters,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              stall_mux_sel,
    output logic              pipe_hold,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  freeze_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int LW = $clog2(LOAD_STALLS + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    hz_state_e   state, state_nxt;
    logic [LW-1:0] lu_cnt, lu_cnt_nxt;
    logic [WW-1:0] wait_cnt;
    hz_ctrl_t    ctrl;
    logic        lu_hit, freeze, take;

    assign lu_hit = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    assign freeze = mem_req && !mem_ready;
    assign take   = (ex_mem_branch && ex_mem_zero) || ex_mem_jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            lu_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
        end
    end

    // Priority chain: freeze beats flush beats load-use stall.
    always_comb begin
        ctrl             = '0;
        ctrl.pc_write    = 1'b1;
        ctrl.if_id_write = 1'b1;
        state_nxt        = state;
        lu_cnt_nxt       = lu_cnt;
        if (freeze) begin
            ctrl.pipe_hold   = 1'b1;
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
        end else if (take) begin
            ctrl.if_flush = 1'b1;
            ctrl.id_flush = 1'b1;
            ctrl.ex_flush = 1'b1;
            state_nxt     = RUN;
            lu_cnt_nxt    = '0;
        end else if ((state == RUN) && lu_hit) begin
            ctrl.stall_mux_sel = 1'b1;
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            if (LOAD_STALLS > 1) begin
                state_nxt  = LU_STALL;
                lu_cnt_nxt = LW'(LOAD_STALLS - 1);
            end
        end else if (state == LU_STALL) begin
            ctrl.stall_mux_sel = 1'b1;
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            lu_cnt_nxt         = lu_cnt - LW'(1);
            if (lu_cnt == LW'(1)) begin
                state_nxt = RUN;
            end
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign stall_mux_sel = ctrl.stall_mux_sel;
    assign pipe_hold     = ctrl.pipe_hold;
    assign if_flush      = ctrl.if_flush;
    assign id_flush      = ctrl.id_flush;
    assign ex_flush      = ctrl.ex_flush;

    // Flag sets on the edge where the consecutive-freeze count reaches MEM_TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (freeze) begin
            if (wait_cnt != WW'(MEM_TIMEOUT)) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
            if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl.stall_mux_sel),
        .clr   (clr_counters),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (freeze),
        .clr   (clr_counters),
        .cnt   (freeze_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take && !freeze),
        .clr   (clr_counters),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
    logic       if_id_uses_rt;
    logic       ex_mem_branch, ex_mem_zero, ex_mem_jump;
    logic       mem_req, mem_ready, clr_counters;

    logic        a_pcw, a_ifw, a_sel, a_hold, a_iff, a_idf, a_exf, a_to;
    logic [1:0]  a_stall, a_freeze, a_flush;
    logic        b_pcw, b_ifw, b_sel, b_hold, b_iff, b_idf, b_exf, b_to;
    logic [15:0] b_stall, b_freeze, b_flush;
    logic [6:0]  ca, cb;

    localparam logic [6:0] NORM = 7'b1100000;
    localparam logic [6:0] STL  = 7'b0010000;
    localparam logic [6:0] FRZ  = 7'b0001000;
    localparam logic [6:0] FLS  = 7'b1100111;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALLS(1), .MEM_TIMEOUT(255), .CNT_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero), .ex_mem_jump(ex_mem_jump),
        .mem_req(mem_req), .mem_ready(mem_ready), .clr_counters(clr_counters),
        .pc_write(a_pcw), .if_id_write(a_ifw), .stall_mux_sel(a_sel), .pipe_hold(a_hold),
        .if_flush(a_iff), .id_flush(a_idf), .ex_flush(a_exf), .mem_timeout(a_to),
        .stall_cnt(a_stall), .freeze_cnt(a_freeze), .flush_cnt(a_flush)
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALLS(3), .MEM_TIMEOUT(5), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero), .ex_mem_jump(ex_mem_jump),
        .mem_req(mem_req), .mem_ready(mem_ready), .clr_counters(clr_counters),
        .pc_write(b_pcw), .if_id_write(b_ifw), .stall_mux_sel(b_sel), .pipe_hold(b_hold),
        .if_flush(b_iff), .id_flush(b_idf), .ex_flush(b_exf), .mem_timeout(b_to),
        .stall_cnt(b_stall), .freeze_cnt(b_freeze), .flush_cnt(b_flush)
    );

    assign ca = {a_pcw, a_ifw, a_sel, a_hold, a_iff, a_idf, a_exf};
    assign cb = {b_pcw, b_ifw, b_sel, b_hold, b_iff, b_idf, b_exf};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_ex_mem_read = 1'b0; id_ex_rt = '0; if_id_rs = '0; if_id_rt = '0;
        if_id_uses_rt = 1'b0; ex_mem_branch = 1'b0; ex_mem_zero = 1'b0; ex_mem_jump = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; clr_counters = 1'b0;
        tick(); tick();
        chk("reset_ctrl_a", 32'(ca), 32'(NORM));
        chk("reset_ctrl_b", 32'(cb), 32'(NORM));
        chk("reset_cnts_b", {b_stall, b_freeze}, 32'd0);
        chk("reset_flush_to", {15'd0, b_to, b_flush}, 32'd0);
        rst_n = 1'b1;
        tick();

        // rs match: single bubble on A, three on B
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5; settle();
        chk("lu_rs_a", 32'(ca), 32'(STL));
        chk("lu_rs_b", 32'(cb), 32'(STL));
        tick();
        chk("lu_rs_a_cnt", 32'(a_stall), 32'd1);
        id_ex_mem_read = 1'b0; id_ex_rt = '0; if_id_rs = '0; settle();
        chk("lu_rs_a_done", 32'(ca), 32'(NORM));
        chk("lu_rs_b_2", 32'(cb), 32'(STL));
        tick();
        chk("lu_rs_b_3", 32'(cb), 32'(STL));
        tick();
        chk("lu_rs_b_done", 32'(cb), 32'(NORM));
        chk("lu_rs_b_cnt", 32'(b_stall), 32'd3);

        // register zero never stalls; rt only counts when uses_rt
        id_ex_mem_read = 1'b1; if_id_uses_rt = 1'b1; settle();
        chk("r0_b", 32'(cb), 32'(NORM));
        chk("r0_a", 32'(ca), 32'(NORM));
        tick();
        id_ex_rt = 5'd7; if_id_rt = 5'd7; if_id_rs = 5'd1; if_id_uses_rt = 1'b0; settle();
        chk("rt_unused_b", 32'(cb), 32'(NORM));
        tick();
        if_id_uses_rt = 1'b1; settle();
        chk("lu_rt_b_1", 32'(cb), 32'(STL));
        chk("lu_rt_a", 32'(ca), 32'(STL));
        tick();
        id_ex_mem_read = 1'b0; settle();
        chk("lu_rt_b_2", 32'(cb), 32'(STL));
        tick();
        chk("lu_rt_b_3", 32'(cb), 32'(STL));
        tick();
        chk("lu_rt_b_done", 32'(cb), 32'(NORM));
        chk("lu_rt_b_cnt", 32'(b_stall), 32'd6);

        // branch taken in second bubble aborts the rest
        id_ex_mem_read = 1'b1; settle();
        chk("fl_b_1", 32'(cb), 32'(STL));
        tick();
        id_ex_mem_read = 1'b0; ex_mem_branch = 1'b1; ex_mem_zero = 1'b1; settle();
        chk("fl_b_take", 32'(cb), 32'(FLS));
        chk("fl_a_take", 32'(ca), 32'(FLS));
        tick();
        ex_mem_branch = 1'b0; ex_mem_zero = 1'b0; settle();
        chk("fl_b_after", 32'(cb), 32'(NORM));
        chk("fl_b_flushcnt", 32'(b_flush), 32'd1);
        chk("fl_b_stallcnt", 32'(b_stall), 32'd7);

        // freeze inside LU_STALL pauses bubble counting
        id_ex_mem_read = 1'b1; settle();
        chk("fz_b_hit", 32'(cb), 32'(STL));
        tick();
        id_ex_mem_read = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("fz_b_hold", 32'(cb), 32'(FRZ));
            chk("fz_a_hold", 32'(ca), 32'(FRZ));
            tick();
        end
        mem_ready = 1'b1; settle();
        chk("fz_b_res2", 32'(cb), 32'(STL));
        tick();
        mem_req = 1'b0; settle();
        chk("fz_b_res3", 32'(cb), 32'(STL));
        tick();
        chk("fz_b_done", 32'(cb), 32'(NORM));
        chk("fz_b_frzcnt", 32'(b_freeze), 32'd4);
        chk("fz_b_stallcnt", 32'(b_stall), 32'd10);
        chk("fz_b_noto", 32'(b_to), 32'd0);
        chk("sat_a_frz", 32'(a_freeze), 32'd3);
        chk("sat_a_stall", 32'(a_stall), 32'd3);

        // memory timeout after five consecutive freeze cycles, sticky
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("to_b_flag", 32'(b_to), (i >= 5) ? 32'd1 : 32'd0);
            tick();
        end
        chk("to_b_set", 32'(b_to), 32'd1);
        mem_ready = 1'b1;
        tick();
        chk("to_b_sticky", 32'(b_to), 32'd1);
        chk("to_b_ctrl", 32'(cb), 32'(NORM));
        chk("to_b_frzcnt", 32'(b_freeze), 32'd10);
        chk("to_a_clear", 32'(a_to), 32'd0);

        // clear beats a simultaneous increment
        mem_req = 1'b0; mem_ready = 1'b0; id_ex_mem_read = 1'b1; clr_counters = 1'b1; settle();
        chk("clr_a_stl", 32'(ca), 32'(STL));
        tick();
        chk("clr_a_stall", 32'(a_stall), 32'd0);
        chk("clr_b_all", 32'(b_stall) | 32'(b_freeze) | 32'(b_flush), 32'd0);
        clr_counters = 1'b0; id_ex_mem_read = 1'b0;
        tick(); tick();
        chk("clr_b_recount", 32'(b_stall), 32'd2);

        // jump flush and async reset mid-stall
        id_ex_mem_read = 1'b1; tick();
        id_ex_mem_read = 1'b0; ex_mem_jump = 1'b1; settle();
        chk("jmp_b", 32'(cb), 32'(FLS));
        ex_mem_jump = 1'b0;
        id_ex_mem_read = 1'b1; tick();
        id_ex_mem_read = 1'b0; settle();
        chk("rst_pre", 32'(cb), 32'(STL));
        rst_n = 1'b0; settle();
        chk("rst_async_ctrl", 32'(cb), 32'(NORM));
        chk("rst_async_to", 32'(b_to), 32'd0);
        chk("rst_async_cnt", 32'(b_stall), 32'd0);
        tick();
        rst_n = 1'b1; tick();
        chk("rst_release", 32'(cb), 32'(NORM));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
